// File: rtl/ll_rd_resp_tracker.sv
// Read-response tracker for fixed-latency RAMs: tags requests, aligns returning
// data with a valid/tag shift pipe, and buffers responses behind a credit counter.
module ll_rd_resp_tracker #(
  parameter int RAM_LATENCY = 2,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int TAG_W       = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               req_valid_i,
  output logic                               req_ready_o,
  input  logic [ADDR_W-1:0]                  req_addr_i,
  input  logic [TAG_W-1:0]                   req_tag_i,
  output logic                               ram_rd_en_o,
  output logic [ADDR_W-1:0]                  ram_rd_addr_o,
  input  logic [DATA_W-1:0]                  ram_rd_data_i,
  output logic                               resp_valid_o,
  input  logic                               resp_ready_i,
  output logic [DATA_W-1:0]                  resp_data_o,
  output logic [TAG_W-1:0]                   resp_tag_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    credits_used_o,
  output logic                               overflow_o
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(FIFO_DEPTH-1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } resp_t;

  logic [CW-1:0]                      credits_q, credits_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic [PW-1:0]                      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                               overflow_q, overflow_d;
  logic [RAM_LATENCY-1:0]             vld_q;
  logic [RAM_LATENCY-1:0][TAG_W-1:0]  tag_q;
  resp_t                              mem_q [FIFO_DEPTH];

  logic accept, push, pop, full, wr_en;

  function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  assign req_ready_o    = (credits_q < DEPTH_C);
  assign accept         = req_valid_i & req_ready_o;
  assign ram_rd_en_o    = accept;
  assign ram_rd_addr_o  = req_addr_i;

  assign push           = vld_q[RAM_LATENCY-1];
  assign full           = (cnt_q == DEPTH_C);
  assign resp_valid_o   = (cnt_q != '0);
  assign pop            = resp_valid_o & resp_ready_i;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign wr_en          = push & (~full | pop);

  assign resp_data_o    = mem_q[rd_ptr_q].data;
  assign resp_tag_o     = mem_q[rd_ptr_q].tag;
  assign credits_used_o = credits_q;
  assign overflow_o     = overflow_q;

  always_comb begin
    credits_d  = credits_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q | (push & full & ~pop);
    case ({accept, pop})
      2'b10:   credits_d = credits_q + 1'b1;
      2'b01:   credits_d = credits_q - 1'b1;
      default: credits_d = credits_q;
    endcase
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (wr_en) wr_ptr_d = nxt_ptr(wr_ptr_q);
    if (pop)   rd_ptr_d = nxt_ptr(rd_ptr_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credits_q  <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      vld_q      <= '0;
      tag_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      credits_q  <= credits_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      vld_q[0]   <= accept;
      tag_q[0]   <= req_tag_i;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
      if (wr_en) mem_q[wr_ptr_q] <= '{data: ram_rd_data_i, tag: tag_q[RAM_LATENCY-1]};
    end
  end
endmodule

// File: tb/tb_ll_rd_resp_tracker.sv
// Bench for ll_rd_resp_tracker: three configurations, one selected at a time,
// checked cycle by cycle against a queue-based model of outstanding requests.
module tb_ll_rd_resp_tracker;
  logic        clk, rst;
  logic        req_valid, resp_ready;
  logic [7:0]  req_addr;
  logic [3:0]  req_tag;
  int          sel;
  logic [7:0]  hist [2];

  logic        rdy_a, en_a, rv_a, ov_a, rdy_b, en_b, rv_b, ov_b, rdy_c, en_c, rv_c, ov_c;
  logic [7:0]  ad_a, ad_b, ad_c;
  logic [31:0] rd_a, rd_b, rd_c, d2, d1;
  logic [3:0]  tg_a, tg_b, tg_c;
  logic [2:0]  cr_a;
  logic [1:0]  cr_b;
  logic [0:0]  cr_c;

  logic        o_req_ready, o_ram_en, o_resp_valid, o_overflow;
  logic [7:0]  o_ram_addr;
  logic [31:0] o_resp_data;
  logic [3:0]  o_resp_tag;
  logic [2:0]  o_credits;

  typedef struct { logic [31:0] d; logic [3:0] t; int ts; } ent_t;
  typedef struct { logic [7:0] a; logic [3:0] t; } req_t;
  ent_t q[$];
  req_t pend[$];

  int n_assert = 0, n_fail = 0, cyc = 0, lat = 2, depth = 4, n_en = 0;

  function automatic logic [31:0] ram_f(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, a + 8'h33};
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // RAM model: address history, data presented 1 or 2 cycles after the read.
  always_ff @(posedge clk) begin
    hist[0] <= req_addr;
    hist[1] <= hist[0];
  end
  assign d2 = ram_f(hist[1]);
  assign d1 = ram_f(hist[0]);

  ll_rd_resp_tracker #(.RAM_LATENCY(2), .FIFO_DEPTH(4)) u_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid && sel == 0), .req_ready_o(rdy_a),
    .req_addr_i(req_addr), .req_tag_i(req_tag), .ram_rd_en_o(en_a), .ram_rd_addr_o(ad_a),
    .ram_rd_data_i(d2), .resp_valid_o(rv_a), .resp_ready_i(resp_ready && sel == 0),
    .resp_data_o(rd_a), .resp_tag_o(tg_a), .credits_used_o(cr_a), .overflow_o(ov_a));
  ll_rd_resp_tracker #(.RAM_LATENCY(2), .FIFO_DEPTH(3)) u_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid && sel == 1), .req_ready_o(rdy_b),
    .req_addr_i(req_addr), .req_tag_i(req_tag), .ram_rd_en_o(en_b), .ram_rd_addr_o(ad_b),
    .ram_rd_data_i(d2), .resp_valid_o(rv_b), .resp_ready_i(resp_ready && sel == 1),
    .resp_data_o(rd_b), .resp_tag_o(tg_b), .credits_used_o(cr_b), .overflow_o(ov_b));
  ll_rd_resp_tracker #(.RAM_LATENCY(1), .FIFO_DEPTH(1)) u_c (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid && sel == 2), .req_ready_o(rdy_c),
    .req_addr_i(req_addr), .req_tag_i(req_tag), .ram_rd_en_o(en_c), .ram_rd_addr_o(ad_c),
    .ram_rd_data_i(d1), .resp_valid_o(rv_c), .resp_ready_i(resp_ready && sel == 2),
    .resp_data_o(rd_c), .resp_tag_o(tg_c), .credits_used_o(cr_c), .overflow_o(ov_c));

  always_comb begin
    {o_req_ready, o_ram_en, o_ram_addr, o_resp_valid} = {rdy_a, en_a, ad_a, rv_a};
    {o_resp_data, o_resp_tag, o_credits, o_overflow}  = {rd_a, tg_a, cr_a, ov_a};
    if (sel == 1) begin
      {o_req_ready, o_ram_en, o_ram_addr, o_resp_valid} = {rdy_b, en_b, ad_b, rv_b};
      {o_resp_data, o_resp_tag, o_credits, o_overflow}  = {rd_b, tg_b, 3'(cr_b), ov_b};
    end else if (sel == 2) begin
      {o_req_ready, o_ram_en, o_ram_addr, o_resp_valid} = {rdy_c, en_c, ad_c, rv_c};
      {o_resp_data, o_resp_tag, o_credits, o_overflow}  = {rd_c, tg_c, 3'(cr_c), ov_c};
    end
  end

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", nm, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One cycle: compare DUT against the model, then advance the model.
  task automatic step();
    logic exp_rdy, acc, ev;
    @(negedge clk);
    exp_rdy = (q.size() < depth);
    acc     = req_valid && exp_rdy;
    ev      = (q.size() > 0) && (q[0].ts + lat + 1 <= cyc);
    if (o_ram_en === 1'b1) n_en++;
    chk("req_ready", 64'(o_req_ready), 64'(exp_rdy));
    chk("ram_rd_en", 64'(o_ram_en), 64'(acc));
    if (acc) chk("ram_rd_addr", 64'(o_ram_addr), 64'(req_addr));
    chk("credits", 64'(o_credits), 64'(q.size()));
    chk("resp_valid", 64'(o_resp_valid), 64'(ev));
    if (ev) begin
      chk("resp_data", 64'(o_resp_data), 64'(q[0].d));
      chk("resp_tag", 64'(o_resp_tag), 64'(q[0].t));
    end
    chk("overflow", 64'(o_overflow), 64'd0);
    if (ev && resp_ready) void'(q.pop_front());
    if (acc) begin
      q.push_back('{ram_f(req_addr), req_tag, cyc});
      void'(pend.pop_front());
    end
    tick();
  endtask

  task automatic run(input int n, input int vp, input int rp);
    for (int i = 0; i < n; i++) begin
      req_valid = (pend.size() > 0) && ($urandom_range(99) < vp);
      if (pend.size() > 0) begin
        req_addr = pend[0].a;
        req_tag  = pend[0].t;
      end else begin
        req_addr = 8'($urandom);
        req_tag  = 4'($urandom);
      end
      resp_ready = ($urandom_range(99) < rp);
      step();
    end
  endtask

  task automatic do_reset(input int s, input int l, input int d);
    rst = 1'b1;
    req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sel = s; lat = l; depth = d;
    q.delete();
    pend.delete();
  endtask

  task automatic add_reqs(input int n);
    for (int i = 0; i < n; i++) pend.push_back('{8'($urandom), 4'($urandom)});
  endtask

  initial begin
    int e0, c0;
    rst = 1'b1; sel = 0; req_valid = 1'b0; resp_ready = 1'b0; req_addr = '0; req_tag = '0;
    // 1: single request, latency and credit return
    do_reset(0, 2, 4);
    run(1, 0, 0);
    pend.push_back('{8'h10, 4'h3});
    run(1, 100, 0);
    run(3, 0, 0);
    chk("t1_hold_data", 64'(o_resp_data), 64'(ram_f(8'h10)));
    run(1, 0, 100);
    run(2, 0, 0);
    // 3: backpressure, only FIFO_DEPTH accepted
    add_reqs(6);
    e0 = n_en;
    run(6, 100, 0);
    run(3, 100, 0);
    chk("t3_accepted", 64'(n_en - e0), 64'd4);
    chk("t3_credits", 64'(o_credits), 64'd4);
    // 4: drain while the remaining two requests get in
    run(20, 100, 100);
    chk("t4_all_accepted", 64'(n_en - e0), 64'd6);
    // 5: reset with reads in flight
    add_reqs(2);
    run(2, 100, 0);
    do_reset(0, 2, 4);
    run(8, 0, 100);
    // random mix on the deep configuration
    add_reqs(120);
    run(400, 70, 60);
    run(20, 100, 100);
    // 2: streaming on DEPTH=3
    do_reset(1, 2, 3);
    add_reqs(20);
    e0 = n_en;
    run(40, 100, 100);
    chk("t2_accepted", 64'(n_en - e0), 64'd20);
    // 6: LAT=1 DEPTH=1 random sweep
    do_reset(2, 1, 1);
    add_reqs(150);
    e0 = n_en; c0 = cyc;
    run(400, 70, 50);
    chk("t6_throughput", 64'((n_en - e0) * 2 <= (cyc - c0) + 1), 64'd1);
    run(200, 100, 100);
    chk("t6_all_accepted", 64'(n_en - e0), 64'd150);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
